// File: rtl/icache_sa.sv
// -----------------------------------------------------------------------------
// icache_sa -- set-associative (1- or 2-way) instruction cache with a single
// outstanding line fill and hit-under-miss.
//
// Parameters
//   LINE_WORDS  32-bit words per line (power of two, 1..8)
//   SETS        number of sets (power of two, 2..64)
//   WAYS        associativity, 1 or 2
//   TAG_HI      highest pc_addr bit stored in the tag
//
// Ports
//   clk          rising-edge clock
//   rst          asynchronous active-low reset
//   rdy          global enable; low freezes every register and array
//   flush        invalidate the whole cache
//   pc_valid     fetch request present
//   pc_addr      fetch byte address (word aligned)
//   hit          combinational: requested word is resident
//   ins_out      combinational: requested word when hit, else 0
//   mem_en       line-fill request to the memory controller
//   addr_to_mem  line-aligned fill address
//   mem_valid    one-cycle pulse: ins_blk carries the fill line
//   ins_blk      fill line, word 0 in bits [31:0]
// -----------------------------------------------------------------------------
module icache_sa #(
  parameter int LINE_WORDS = 2,
  parameter int SETS       = 16,
  parameter int WAYS       = 2,
  parameter int TAG_HI     = 17
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    rdy,
  input  logic                    flush,
  input  logic                    pc_valid,
  input  logic [31:0]             pc_addr,
  output logic                    hit,
  output logic [31:0]             ins_out,
  output logic                    mem_en,
  output logic [31:0]             addr_to_mem,
  input  logic                    mem_valid,
  input  logic [32*LINE_WORDS-1:0] ins_blk
);

  localparam int OB    = $clog2(4 * LINE_WORDS);  // byte-offset bits
  localparam int IB    = $clog2(SETS);            // index bits
  localparam int TAG_LO = OB + IB;
  localparam int TW    = TAG_HI - TAG_LO + 1;
  localparam int LW    = 32 * LINE_WORDS;

  typedef enum logic [1:0] {IDLE, FILL, DROP} state_t;

  // Storage: valid/LRU are control state and get reset; tag/data are not.
  logic [SETS-1:0] valid_q [WAYS];
  logic [SETS-1:0] lru_q;                 // 1 bit per set: least-recently-used way
  logic [TW-1:0]   tag_q   [WAYS][SETS];
  logic [LW-1:0]   data_q  [WAYS][SETS];

  // Fill bookkeeping latched when the miss is issued.
  state_t          state_q, state_d;
  logic            mem_en_d;
  logic [31:0]     addr_d;
  logic [IB-1:0]   fill_set_q, fill_set_d;
  logic [TW-1:0]   fill_tag_q, fill_tag_d;
  logic            fill_way_q, fill_way_d;
  logic            fill_we;

  // Address split.
  logic [IB-1:0] req_set;
  logic [TW-1:0] req_tag;
  logic [31:0]   word_idx;
  assign req_set  = pc_addr[TAG_LO-1:OB];
  assign req_tag  = pc_addr[TAG_HI:TAG_LO];
  assign word_idx = 32'(pc_addr[OB-1:0] >> 2);

  // Lookup and word select.
  logic          any_match;
  logic          hit_way;
  logic [LW-1:0] hit_line;

  // NOTE: every signal written in an always_comb gets a default first so no
  // path through the block leaves it unassigned (which would infer a latch).
  always_comb begin
    any_match = 1'b0;
    hit_way   = 1'b0;
    hit_line  = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid_q[w][req_set] && tag_q[w][req_set] == req_tag) begin
        any_match = 1'b1;
        hit_way   = 1'(w);
        hit_line  = data_q[w][req_set];
      end
    end
    hit     = pc_valid & ~flush & any_match;
    ins_out = '0;
    if (hit) begin
      for (int k = 0; k < LINE_WORDS; k++) begin
        if (word_idx == 32'(k)) ins_out = hit_line[k*32 +: 32];
      end
    end
  end

  // Victim: first invalid way (way 0 preferred), otherwise the LRU way.
  logic victim;
  logic found_free;
  always_comb begin
    victim     = 1'b0;
    found_free = 1'b0;
    for (int w = 0; w < WAYS; w++) begin
      if (!found_free && !valid_q[w][req_set]) begin
        victim     = 1'(w);
        found_free = 1'b1;
      end
    end
    if (!found_free && WAYS == 2) victim = lru_q[req_set];
  end

  // Next-state / output logic. A flush seen in FILL keeps the request alive
  // (the memory controller still answers it) but the answer gets dropped.
  always_comb begin
    state_d    = state_q;
    mem_en_d   = mem_en;
    addr_d     = addr_to_mem;
    fill_set_d = fill_set_q;
    fill_tag_d = fill_tag_q;
    fill_way_d = fill_way_q;
    fill_we    = 1'b0;
    case (state_q)
      IDLE: begin
        if (pc_valid && !hit && !flush) begin
          mem_en_d   = 1'b1;
          addr_d     = {pc_addr[31:OB], {OB{1'b0}}};
          fill_set_d = req_set;
          fill_tag_d = req_tag;
          fill_way_d = victim;
          state_d    = FILL;
        end
      end
      FILL: begin
        if (mem_valid) begin
          fill_we  = ~flush;
          mem_en_d = 1'b0;
          addr_d   = '0;
          state_d  = IDLE;
        end else if (flush) begin
          state_d = DROP;
        end
      end
      DROP: begin
        if (mem_valid) begin
          mem_en_d = 1'b0;
          addr_d   = '0;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      mem_en      <= 1'b0;
      addr_to_mem <= '0;
      fill_set_q  <= '0;
      fill_tag_q  <= '0;
      fill_way_q  <= 1'b0;
    end else if (rdy) begin
      state_q     <= state_d;
      mem_en      <= mem_en_d;
      addr_to_mem <= addr_d;
      fill_set_q  <= fill_set_d;
      fill_tag_q  <= fill_tag_d;
      fill_way_q  <= fill_way_d;
    end
  end

  // Valid and LRU bits. A fill in the same cycle as a hit to the same set
  // wins the LRU update, since the filled line is the newest.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int w = 0; w < WAYS; w++) valid_q[w] <= '0;
      lru_q <= '0;
    end else if (rdy) begin
      if (flush) begin
        for (int w = 0; w < WAYS; w++) valid_q[w] <= '0;
        lru_q <= '0;
      end else begin
        if (hit && WAYS == 2) lru_q[req_set] <= ~hit_way;
        if (fill_we) begin
          for (int w = 0; w < WAYS; w++) begin
            if (fill_way_q == 1'(w)) valid_q[w][fill_set_q] <= 1'b1;
          end
          if (WAYS == 2) lru_q[fill_set_q] <= ~fill_way_q;
        end
      end
    end
  end

  // NOTE: tag/data arrays carry no reset; valid bits gate every use, and
  // leaving them unreset lets them map onto plain RAM.
  always_ff @(posedge clk) begin
    if (rdy && fill_we) begin
      for (int w = 0; w < WAYS; w++) begin
        if (fill_way_q == 1'(w)) begin
          data_q[w][fill_set_q] <= ins_blk;
          tag_q[w][fill_set_q]  <= fill_tag_q;
        end
      end
    end
  end

endmodule

// File: tb/tb_icache_sa.sv
// -----------------------------------------------------------------------------
// tb_icache_sa -- directed self-checking bench for icache_sa.
// Instance a: default parameters (2-way, 2 words/line, 16 sets).
// Instance b: WAYS=1, LINE_WORDS=4, SETS=32.
// Expected values are queued when stimulus is applied and popped by check()
// when the corresponding DUT output is sampled.
// -----------------------------------------------------------------------------
module tb_icache_sa;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance a
  logic        rst, rdy, flush, pc_valid, mem_valid;
  logic [31:0] pc_addr;
  logic [63:0] ins_blk;
  logic        hit, mem_en;
  logic [31:0] ins_out, addr_to_mem;

  // Instance b
  logic         b_rst, b_rdy, b_flush, b_pc_valid, b_mem_valid;
  logic [31:0]  b_pc_addr;
  logic [127:0] b_ins_blk;
  logic         b_hit, b_mem_en;
  logic [31:0]  b_ins_out, b_addr_to_mem;

  icache_sa dut_a (
    .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
    .pc_valid(pc_valid), .pc_addr(pc_addr),
    .hit(hit), .ins_out(ins_out),
    .mem_en(mem_en), .addr_to_mem(addr_to_mem),
    .mem_valid(mem_valid), .ins_blk(ins_blk)
  );

  icache_sa #(.LINE_WORDS(4), .SETS(32), .WAYS(1), .TAG_HI(17)) dut_b (
    .clk(clk), .rst(b_rst), .rdy(b_rdy), .flush(b_flush),
    .pc_valid(b_pc_valid), .pc_addr(b_pc_addr),
    .hit(b_hit), .ins_out(b_ins_out),
    .mem_en(b_mem_en), .addr_to_mem(b_addr_to_mem),
    .mem_valid(b_mem_valid), .ins_blk(b_ins_blk)
  );

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic want(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic check(input logic [31:0] obs);
    exp_t e;
    n_tests++;
    if (sb.size() == 0) begin
      n_fail++;
      $error("FAIL scoreboard_empty: observed %h, required a queued value", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val) else begin
        n_fail++;
        $error("FAIL %s: observed %h required %h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Look up an address on instance a without letting the request reach an
  // edge, so no miss is issued and LRU is untouched.
  task automatic probe(input logic [31:0] a, input logic eh, input logic [31:0] ed);
    pc_addr  = a;
    pc_valid = 1'b1;
    want($sformatf("hit@%h", a), 32'(eh));
    want($sformatf("ins_out@%h", a), ed);
    #1;
    check(32'(hit));
    check(ins_out);
    pc_valid = 1'b0;
    step();
  endtask

  // Miss on instance a and complete the fill.
  task automatic fill(input logic [31:0] a, input logic [63:0] blk);
    pc_addr  = a;
    pc_valid = 1'b1;
    step();
    pc_valid = 1'b0;
    want($sformatf("mem_en_req@%h", a), 32'd1);
    want($sformatf("addr_to_mem@%h", a), a & ~32'h7);
    check(32'(mem_en));
    check(addr_to_mem);
    mem_valid = 1'b1;
    ins_blk   = blk;
    step();
    mem_valid = 1'b0;
    want($sformatf("mem_en_done@%h", a), 32'd0);
    check(32'(mem_en));
  endtask

  task automatic b_probe(input logic [31:0] a, input logic eh, input logic [31:0] ed);
    b_pc_addr  = a;
    b_pc_valid = 1'b1;
    want($sformatf("b_hit@%h", a), 32'(eh));
    want($sformatf("b_ins_out@%h", a), ed);
    #1;
    check(32'(b_hit));
    check(b_ins_out);
    b_pc_valid = 1'b0;
    step();
  endtask

  task automatic b_fill(input logic [31:0] a, input logic [127:0] blk);
    b_pc_addr  = a;
    b_pc_valid = 1'b1;
    step();
    b_pc_valid = 1'b0;
    want($sformatf("b_mem_en_req@%h", a), 32'd1);
    want($sformatf("b_addr_to_mem@%h", a), a & ~32'hF);
    check(32'(b_mem_en));
    check(b_addr_to_mem);
    b_mem_valid = 1'b1;
    b_ins_blk   = blk;
    step();
    b_mem_valid = 1'b0;
    want($sformatf("b_mem_en_done@%h", a), 32'd0);
    check(32'(b_mem_en));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed no finish, required finish within 1ms");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b0; rdy = 1'b1; flush = 1'b0; pc_valid = 1'b0; pc_addr = '0;
    mem_valid = 1'b0; ins_blk = '0;
    b_rst = 1'b0; b_rdy = 1'b1; b_flush = 1'b0; b_pc_valid = 1'b0; b_pc_addr = '0;
    b_mem_valid = 1'b0; b_ins_blk = '0;

    // Reset state
    #2;
    want("rst_mem_en", 32'd0);
    want("rst_addr_to_mem", 32'd0);
    want("rst_hit", 32'd0);
    check(32'(mem_en));
    check(addr_to_mem);
    check(32'(hit));
    step();
    step();
    rst   = 1'b1;
    b_rst = 1'b1;
    step();

    // Cold miss on 0x1004
    pc_addr  = 32'h0000_1004;
    pc_valid = 1'b1;
    want("cold_hit_before", 32'd0);
    #1;
    check(32'(hit));
    step();
    pc_valid = 1'b0;
    want("cold_mem_en", 32'd1);
    want("cold_addr", 32'h0000_1000);
    check(32'(mem_en));
    check(addr_to_mem);
    step();
    want("cold_mem_en_wait", 32'd1);
    check(32'(mem_en));
    mem_valid = 1'b1;
    ins_blk   = 64'hBBBB_BBBB_AAAA_AAAA;
    pc_valid  = 1'b1;
    want("no_bypass_hit", 32'd0);
    #1;
    check(32'(hit));
    step();
    mem_valid = 1'b0;
    want("cold_mem_en_done", 32'd0);
    want("cold_addr_done", 32'd0);
    want("cold_hit_after", 32'd1);
    want("cold_word1", 32'hBBBB_BBBB);
    check(32'(mem_en));
    check(addr_to_mem);
    check(32'(hit));
    check(ins_out);
    pc_valid = 1'b0;
    probe(32'h0000_1000, 1'b1, 32'hAAAA_AAAA);

    // Flush in IDLE: masks hit, no request, valid bits cleared
    pc_addr  = 32'h0000_1000;
    pc_valid = 1'b1;
    flush    = 1'b1;
    want("flush_masks_hit", 32'd0);
    #1;
    check(32'(hit));
    step();
    flush = 1'b0;
    want("flush_no_request", 32'd0);
    want("flush_cleared_hit", 32'd0);
    check(32'(mem_en));
    check(32'(hit));
    pc_valid = 1'b0;
    step();

    // 2-way conflict in set 0
    fill(32'h0000_0000, 64'h0000_0011_0000_0010);
    fill(32'h0000_0100, 64'h0000_0111_0000_0110);
    probe(32'h0000_0000, 1'b1, 32'h0000_0010);
    probe(32'h0000_0104, 1'b1, 32'h0000_0111);
    pc_addr  = 32'h0000_0000;
    pc_valid = 1'b1;
    step();
    pc_valid = 1'b0;
    fill(32'h0000_0200, 64'h0000_0211_0000_0210);
    probe(32'h0000_0000, 1'b1, 32'h0000_0010);
    probe(32'h0000_0200, 1'b1, 32'h0000_0210);
    probe(32'h0000_0100, 1'b0, 32'h0000_0000);

    // Flush during fill: request held, data dropped, re-request
    pc_addr  = 32'h0000_2000;
    pc_valid = 1'b1;
    step();
    pc_valid = 1'b0;
    flush    = 1'b1;
    step();
    flush = 1'b0;
    want("drop_mem_en", 32'd1);
    want("drop_addr", 32'h0000_2000);
    check(32'(mem_en));
    check(addr_to_mem);
    step();
    want("drop_mem_en_wait", 32'd1);
    check(32'(mem_en));
    mem_valid = 1'b1;
    ins_blk   = 64'h0000_2221_0000_2220;
    step();
    mem_valid = 1'b0;
    want("drop_mem_en_done", 32'd0);
    want("drop_addr_done", 32'd0);
    check(32'(mem_en));
    check(addr_to_mem);
    probe(32'h0000_2000, 1'b0, 32'h0);
    probe(32'h0000_0000, 1'b0, 32'h0);
    pc_addr  = 32'h0000_2000;
    pc_valid = 1'b1;
    step();
    pc_valid = 1'b0;
    want("rereq_mem_en", 32'd1);
    want("rereq_addr", 32'h0000_2000);
    check(32'(mem_en));
    check(addr_to_mem);
    flush     = 1'b1;
    mem_valid = 1'b1;
    step();
    flush     = 1'b0;
    mem_valid = 1'b0;
    want("flush_mv_mem_en", 32'd0);
    want("flush_mv_addr", 32'd0);
    check(32'(mem_en));
    check(addr_to_mem);
    probe(32'h0000_2000, 1'b0, 32'h0);

    // Hit-under-miss
    fill(32'h0000_0008, 64'h0000_0809_0000_0808);
    pc_addr  = 32'h0000_3000;
    pc_valid = 1'b1;
    step();
    pc_addr = 32'h0000_0008;
    want("hum_hit", 32'd1);
    want("hum_data", 32'h0000_0808);
    want("hum_mem_en", 32'd1);
    want("hum_addr", 32'h0000_3000);
    #1;
    check(32'(hit));
    check(ins_out);
    check(32'(mem_en));
    check(addr_to_mem);
    step();
    pc_addr = 32'h0000_0010;   // a second miss while FILL must not be issued
    step();
    want("hum_no_second_miss", 32'h0000_3000);
    check(addr_to_mem);
    pc_valid  = 1'b0;
    mem_valid = 1'b1;
    ins_blk   = 64'h0000_3031_0000_3030;
    step();
    mem_valid = 1'b0;
    want("hum_mem_en_done", 32'd0);
    check(32'(mem_en));
    probe(32'h0000_3004, 1'b1, 32'h0000_3031);

    // rdy low freezes a pending miss
    rdy      = 1'b0;
    pc_addr  = 32'h0000_4000;
    pc_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      want($sformatf("frozen_mem_en_%0d", i), 32'd0);
      check(32'(mem_en));
    end
    rdy = 1'b1;
    step();
    pc_valid = 1'b0;
    want("unfrozen_mem_en", 32'd1);
    want("unfrozen_addr", 32'h0000_4000);
    check(32'(mem_en));
    check(addr_to_mem);

    // Async reset mid-FILL
    rst = 1'b0;
    #1;
    want("async_rst_mem_en", 32'd0);
    want("async_rst_addr", 32'd0);
    check(32'(mem_en));
    check(addr_to_mem);
    step();
    step();
    rst       = 1'b1;
    mem_valid = 1'b1;
    ins_blk   = 64'h0000_4441_0000_4440;
    step();
    mem_valid = 1'b0;
    want("late_mv_mem_en", 32'd0);
    check(32'(mem_en));
    probe(32'h0000_4000, 1'b0, 32'h0);
    probe(32'h0000_0008, 1'b0, 32'h0);
    probe(32'h0000_3000, 1'b0, 32'h0);

    // Parameter sweep: 1-way, 4 words/line, 32 sets
    b_fill(32'h0000_1004, 128'hDDDD_DDDD_CCCC_CCCC_BBBB_BBBB_AAAA_AAAA);
    b_probe(32'h0000_1004, 1'b1, 32'hBBBB_BBBB);
    b_probe(32'h0000_100C, 1'b1, 32'hDDDD_DDDD);
    b_probe(32'h0000_1000, 1'b1, 32'hAAAA_AAAA);
    b_fill(32'h0000_0000, 128'h0000_0003_0000_0002_0000_0001_0000_0000);
    b_probe(32'h0000_1000, 1'b0, 32'h0);
    b_probe(32'h0000_0008, 1'b1, 32'h0000_0002);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/icache_sa.md
ICACHE_SA -- requirements
Module: icache_sa

Interface
REQ-001 Parameter LINE_WORDS, default 2, 32-bit words per line; power of two, 1..8.
REQ-002 Parameter SETS, default 16, number of sets; power of two, 2..64.
REQ-003 Parameter WAYS, default 2, associativity; legal values 1 or 2.
REQ-004 Parameter TAG_HI, default 17, highest pc_addr bit used as tag; bits above ignored.
REQ-005 clk  input  1  sole clock; all state updates on rising edge.
REQ-006 rst  input  1  reset, asynchronous, active-low.
REQ-007 rdy  input  1  global enable; low freezes all state.
REQ-008 flush  input  1  invalidate entire cache.
REQ-009 pc_valid  input  1  fetch request present.
REQ-010 pc_addr  input  32  fetch address, bits [1:0] = 00.
REQ-011 hit  output  1  combinational: requested word present.
REQ-012 ins_out  output  32  combinational: requested word when hit, else 0.
REQ-013 mem_en  output  1  line-fill request to memory controller.
REQ-014 addr_to_mem  output  32  line-aligned fill address.
REQ-015 mem_valid  input  1  one-cycle pulse: fill data valid.
REQ-016 ins_blk  input  32*LINE_WORDS  fill line, word 0 in bits [31:0].

Function
REQ-017 Address split: OB = log2(4*LINE_WORDS) offset bits; index = pc_addr[OB+log2(SETS)-1 : OB]; tag = pc_addr[TAG_HI : OB+log2(SETS)].
REQ-018 Per set per way: valid bit, tag, line data; per set (WAYS=2): one LRU bit naming the least-recently-used way.
REQ-019 hit = pc_valid & ~flush & (any way in set with valid & tag match); ins_out = word pc_addr[OB-1:2] of matching line, 0 when hit=0.
REQ-020 FSM states IDLE, FILL, DROP; reset state IDLE.
REQ-021 IDLE, rdy & pc_valid & ~hit & ~flush: mem_en<=1, addr_to_mem<={pc_addr[31:OB], OB zeros}, latch victim way, -> FILL.
REQ-022 Victim: WAYS=1 way 0; WAYS=2 first invalid way (way 0 preferred), else way named by LRU bit.
REQ-023 FILL, mem_valid & ~flush: write ins_blk, tag, valid=1 into latched set/way; LRU bit <= other way; mem_en<=0; addr_to_mem<=0; -> IDLE.
REQ-024 Fill data visible on hit the cycle after mem_valid (no bypass).
REQ-025 On any cycle with rdy & hit (any state): LRU bit of that set <= way not hit.
REQ-026 Hits during FILL/DROP to resident lines served normally (hit-under-miss); no second miss issued until IDLE.
REQ-027 flush with rdy: all valid bits cleared next edge; LRU bits cleared; in IDLE no request issued that cycle.
REQ-028 flush in FILL: -> DROP, mem_en held 1, addr_to_mem held; flush coincident with mem_valid in FILL: data discarded, mem_en<=0, -> IDLE.
REQ-029 DROP, mem_valid: data discarded, mem_en<=0, addr_to_mem<=0, -> IDLE; further flush in DROP only reclears valid bits.
REQ-030 mem_en never deasserts before mem_valid; at most one outstanding fill.
REQ-031 rdy=0: FSM, arrays, LRU, outputs regs frozen; mem_valid pulses while rdy=0 are not expected by the memory controller.

Reset
REQ-032 rst low asynchronously: state IDLE, all valid and LRU bits 0, mem_en=0, addr_to_mem=0; data/tag arrays not reset.
REQ-033 rst low mid-FILL aborts the fill; any later mem_valid in IDLE is ignored.

Verification
REQ-034 Cold miss (defaults): pc_addr=0x0000_1004 -> next cycle mem_en=1, addr_to_mem=0x0000_1000; mem_valid with ins_blk=0xBBBB_BBBB_AAAA_AAAA -> next cycle hit=1, ins_out=0xBBBB_BBBB; 0x1000 -> 0xAAAA_AAAA.
REQ-035 2-way conflict: fill 0x0000_0000 then 0x0000_0100 (same set 0) -> both hit; access 0x0000_0000, then miss on 0x0000_0200 -> replaces way holding 0x100; 0x000 still hits.
REQ-036 Flush during fill: miss 0x0000_2000, flush one cycle -> mem_en stays 1; mem_valid -> mem_en=0, 0x2000 still misses, re-request issued.
REQ-037 Hit-under-miss: 0x0000_0008 resident, miss on 0x0000_3000 pending, switch pc to 0x0008 -> hit=1 with correct data, mem_en unchanged.
REQ-038 rdy=0 for 5 cycles with pending miss in IDLE -> mem_en stays 0; rdy=1 -> request issued next edge.
REQ-039 Async reset mid-FILL -> mem_en=0 immediately, previously filled addresses miss after reset release; sweep WAYS=1, LINE_WORDS=4, SETS=32 with REQ-034.
